cv_write_back: RTL and testbench

//  Write side of the VRAM->VRAM copy path. Pops the pixel-pair FIFO filled by the copy read state machine.

---
 rtl/cv_write_back_pkg.sv | 41 ++++
 rtl/cv_write_back_mask_merge.sv | 25 ++
 rtl/cv_write_back.sv | 187 ++++++++++++++++++
 tb/tb_cv_write_back.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv_write_back_pkg.sv
// Shared definitions for the VRAM->VRAM copy path: pair-FIFO word layout,
// write-back FSM states and the unpacked entry view.
package cv_write_back_pkg;

  localparam int CV_PIX0    = 0;
  localparam int CV_PIX1    = 16;
  localparam int CV_V0      = 32;
  localparam int CV_V1      = 33;
  localparam int CV_CRLF    = 34;
  localparam int CV_LAST    = 35;
  localparam int CV_ENTRY_W = 36;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_RDDST = 3'd2,
    ST_WRITE = 3'd3,
    ST_ADV   = 3'd4
  } cv_state_e;

  typedef struct packed {
    logic        last;
    logic        crlf;
    logic        v1;
    logic        v0;
    logic [15:0] pix1;
    logic [15:0] pix0;
  } cv_entry_t;

  function automatic cv_entry_t cv_unpack(input logic [CV_ENTRY_W-1:0] w);
    cv_entry_t e;
    e.pix0 = w[CV_PIX0 +: 16];
    e.pix1 = w[CV_PIX1 +: 16];
    e.v0   = w[CV_V0];
    e.v1   = w[CV_V1];
    e.crlf = w[CV_CRLF];
    e.last = w[CV_LAST];
    return e;
  endfunction

endpackage

// File: rtl/cv_write_back_mask_merge.sv
// Combinational PSX mask handling for one pixel pair: per-pixel enables from
// valid bits and destination mask bits, and forced bit 15 when set-mask is on.
module cv_mask_merge
  import cv_write_back_pkg::*;
(
  input  cv_entry_t   entry,
  input  logic [1:0]  dmask,
  input  logic        check_mask,
  input  logic        set_mask,
  output logic [31:0] wr_data,
  output logic [1:0]  wr_mask
);

  logic [15:0] force_bits;
  logic        unused_bits;

  assign force_bits  = {set_mask, 15'b0};
  assign unused_bits = ^{entry.crlf, entry.last};

  always_comb begin
    wr_mask = {entry.v1, entry.v0} & ~(check_mask ? dmask : 2'b00);
    wr_data = {entry.pix1 | force_bits, entry.pix0 | force_bits};
  end

endmodule

// File: rtl/cv_write_back.sv
// Write side of the VRAM->VRAM copy: pops pixel pairs, optionally pre-reads the
// destination for check-mask, writes merged pairs and walks the destination rectangle.
module cv_write_back
  import cv_write_back_pkg::*;
#(
  parameter int XPW = 9,
  parameter int YW  = 9
) (
  input  logic                  clk,
  input  logic                  nRst,
  input  logic                  active,
  input  logic [9:0]            dstX,
  input  logic [YW-1:0]         dstY,
  input  logic                  checkMask,
  input  logic                  setMask,
  input  logic                  fifoEmpty,
  input  logic [CV_ENTRY_W-1:0] fifoData,
  output logic                  fifoPop,
  output logic                  rdReq,
  output logic [YW+XPW-1:0]     rdAddr,
  input  logic                  rdAck,
  input  logic [31:0]           rdData,
  output logic                  wrReq,
  output logic [YW+XPW-1:0]     wrAddr,
  output logic [31:0]           wrData,
  output logic [1:0]            wrMask,
  input  logic                  wrAck,
  output logic                  exitSig
);

  cv_state_e      state_q, state_d;
  logic           active_q, active_d;
  logic [XPW-1:0] xpair_q, xpair_d;
  logic [XPW-1:0] start_q, start_d;
  logic [YW-1:0]  y_q, y_d;
  cv_entry_t      entry_q, entry_d;
  logic [1:0]     dmask_q, dmask_d;
  logic [31:0]    wr_data_q, wr_data_d;
  logic [1:0]     wr_mask_q, wr_mask_d;
  logic           rd_req_q, rd_req_d;
  logic           wr_req_q, wr_req_d;
  logic           exit_q, exit_d;

  cv_entry_t      fifo_entry;
  cv_entry_t      merge_entry;
  logic [1:0]     merge_dmask;
  logic [31:0]    merge_data;
  logic [1:0]     merge_mask;
  logic           unused_bits;

  assign fifo_entry  = cv_unpack(fifoData);
  assign unused_bits = ^{dstX[0], rdData[30:16], rdData[14:0]};

  // Merge sees the values that will be in flight next cycle so WRITE outputs load on entry.
  always_comb begin
    merge_entry = entry_q;
    merge_dmask = dmask_q;
    if (state_q == ST_FETCH) begin
      merge_entry = fifo_entry;
      merge_dmask = 2'b00;
    end else if (state_q == ST_RDDST) begin
      merge_dmask = {rdData[31], rdData[15]};
    end
  end

  cv_mask_merge u_merge (
    .entry      (merge_entry),
    .dmask      (merge_dmask),
    .check_mask (checkMask),
    .set_mask   (setMask),
    .wr_data    (merge_data),
    .wr_mask    (merge_mask)
  );

  always_comb begin
    state_d   = state_q;
    active_d  = active;
    xpair_d   = xpair_q;
    start_d   = start_q;
    y_d       = y_q;
    entry_d   = entry_q;
    dmask_d   = dmask_q;
    wr_data_d = wr_data_q;
    wr_mask_d = wr_mask_q;
    fifoPop   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (active && !active_q) begin
          xpair_d = dstX[XPW:1];
          start_d = dstX[XPW:1];
          y_d     = dstY;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (!active) begin
          state_d = ST_IDLE;
        end else if (!fifoEmpty) begin
          fifoPop = 1'b1;
          entry_d = fifo_entry;
          dmask_d = 2'b00;
          if (fifo_entry.v0 || fifo_entry.v1)
            state_d = checkMask ? ST_RDDST : ST_WRITE;
          else
            state_d = ST_ADV;
        end
      end
      ST_RDDST: begin
        if (rdAck) begin
          dmask_d = {rdData[31], rdData[15]};
          if (!active)
            state_d = ST_IDLE;
          else
            state_d = (merge_mask != 2'b00) ? ST_WRITE : ST_ADV;
        end
      end
      ST_WRITE: begin
        if (wrAck)
          state_d = active ? ST_ADV : ST_IDLE;
      end
      ST_ADV: begin
        if (entry_q.crlf) begin
          xpair_d = start_q;
          y_d     = y_q + 1'b1;
        end else begin
          xpair_d = xpair_q + 1'b1;
        end
        state_d = (entry_q.last || !active) ? ST_IDLE : ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase

    rd_req_d = (state_d == ST_RDDST);
    wr_req_d = (state_d == ST_WRITE);
    exit_d   = (state_d == ST_ADV) && entry_d.last;

    // Write payload is frozen on entry to WRITE and held until the ack.
    if (state_d == ST_WRITE) begin
      if (state_q != ST_WRITE) begin
        wr_data_d = merge_data;
        wr_mask_d = merge_mask;
      end
    end else begin
      wr_mask_d = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q   <= ST_IDLE;
      active_q  <= 1'b0;
      xpair_q   <= '0;
      start_q   <= '0;
      y_q       <= '0;
      entry_q   <= '0;
      dmask_q   <= 2'b00;
      wr_data_q <= '0;
      wr_mask_q <= 2'b00;
      rd_req_q  <= 1'b0;
      wr_req_q  <= 1'b0;
      exit_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      xpair_q   <= xpair_d;
      start_q   <= start_d;
      y_q       <= y_d;
      entry_q   <= entry_d;
      dmask_q   <= dmask_d;
      wr_data_q <= wr_data_d;
      wr_mask_q <= wr_mask_d;
      rd_req_q  <= rd_req_d;
      wr_req_q  <= wr_req_d;
      exit_q    <= exit_d;
    end
  end

  assign rdReq   = rd_req_q;
  assign wrReq   = wr_req_q;
  assign rdAddr  = {y_q, xpair_q};
  assign wrAddr  = {y_q, xpair_q};
  assign wrData  = wr_data_q;
  assign wrMask  = wr_mask_q;
  assign exitSig = exit_q;

endmodule

// File: tb/tb_cv_write_back.sv
// Self-checking bench for cv_write_back: show-ahead FIFO and VRAM responder
// models, a rectangle-walk reference model, directed table rows and random commands.
module tb_cv_write_back;

  logic        clk = 1'b0;
  logic        nRst, active;
  logic [9:0]  dstX;
  logic [8:0]  dstY;
  logic        checkMask, setMask;
  logic        fifoEmpty;
  logic [35:0] fifoData;
  logic        fifoPop;
  logic        rdReq, rdAck;
  logic [17:0] rdAddr, wrAddr;
  logic [31:0] rdData, wrData;
  logic        wrReq, wrAck;
  logic [1:0]  wrMask;
  logic        exitSig;

  always #5 clk = ~clk;

  cv_write_back #(.XPW(9), .YW(9)) dut (
    .clk(clk), .nRst(nRst), .active(active), .dstX(dstX), .dstY(dstY),
    .checkMask(checkMask), .setMask(setMask), .fifoEmpty(fifoEmpty),
    .fifoData(fifoData), .fifoPop(fifoPop), .rdReq(rdReq), .rdAddr(rdAddr),
    .rdAck(rdAck), .rdData(rdData), .wrReq(wrReq), .wrAddr(wrAddr),
    .wrData(wrData), .wrMask(wrMask), .wrAck(wrAck), .exitSig(exitSig)
  );

  typedef struct { logic [9:0] dx; logic [8:0] dy; bit cm; bit sm; } cfg_t;
  typedef struct { logic [17:0] addr; logic [31:0] data; logic [1:0] mask; int cyc; } wr_t;
  typedef struct {
    cfg_t c; logic [15:0] p0; logic [15:0] p1; logic [1:0] v; logic [31:0] dst;
    int exp_wr; logic [17:0] exp_addr; logic [31:0] exp_data; logic [1:0] exp_mask;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;

  // Show-ahead pair FIFO: the bench pushes at the tail, the DUT pops the head.
  logic [35:0] fifo_mem [0:255];
  int fifo_head = 0;
  int fifo_tail = 0;
  int pop_while_empty = 0;
  assign fifoEmpty = (fifo_head == fifo_tail);
  assign fifoData  = fifo_mem[fifo_head[7:0]];

  always @(posedge clk) begin
    if (fifoPop) begin
      if (fifoEmpty) pop_while_empty <= pop_while_empty + 1;
      else fifo_head <= fifo_head + 1;
    end
  end

  // Destination VRAM: untouched words come from a fixed hash of the address.
  logic [31:0] vram  [int];
  logic [31:0] mvram [int];

  function automatic logic [31:0] bg(input int a);
    logic [31:0] h;
    h = a * 32'h9E3779B1;
    return h ^ (h >> 13) ^ 32'h5A5A_1234;
  endfunction

  int rd_delay = 0, wr_delay = 0, rd_cnt = 0, wr_cnt = 0;
  int cyc = 0, exit_count = 0, exit_cyc = 0, both_req = 0;
  logic [49:0] wr_first;
  bit          wr_stable;
  wr_t         got_wr[$];
  bit          stable_log[$];

  // Memory responder: acks after a programmable wait, logs writes and exit pulses.
  always @(negedge clk) begin
    logic [31:0] w;
    cyc++;
    rdAck = 1'b0;
    wrAck = 1'b0;
    if (rdReq && wrReq) both_req++;
    if (rdReq) begin
      rdData = $urandom;
      if (rd_cnt >= rd_delay) begin
        rdAck  = 1'b1;
        rdData = vram.exists(int'(rdAddr)) ? vram[int'(rdAddr)] : bg(int'(rdAddr));
        rd_cnt = 0;
      end else rd_cnt++;
    end else rd_cnt = 0;
    if (wrReq) begin
      if (wr_cnt == 0) begin
        wr_first  = {wrAddr, wrData};
        wr_stable = 1'b1;
      end else if (wr_first != {wrAddr, wrData}) wr_stable = 1'b0;
      if (wr_cnt >= wr_delay) begin
        wrAck = 1'b1;
        got_wr.push_back('{addr: wrAddr, data: wrData, mask: wrMask, cyc: cyc});
        stable_log.push_back(wr_stable);
        w = vram.exists(int'(wrAddr)) ? vram[int'(wrAddr)] : bg(int'(wrAddr));
        if (wrMask[0]) w[15:0]  = wrData[15:0];
        if (wrMask[1]) w[31:16] = wrData[31:16];
        vram[int'(wrAddr)] = w;
        wr_cnt = 0;
      end else wr_cnt++;
    end else wr_cnt = 0;
    if (exitSig) begin
      exit_count++;
      exit_cyc = cyc;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input cfg_t c);
    @(negedge clk);
    dstX      = c.dx;
    dstY      = c.dy;
    checkMask = c.cm;
    setMask   = c.sm;
  endtask

  function automatic logic [35:0] mk(input logic [15:0] p0, input logic [15:0] p1,
                                     input logic [1:0] v, input bit crlf, input bit last);
    return {last, crlf, v[1], v[0], p1, p0};
  endfunction

  task automatic push(input logic [35:0] e);
    fifo_mem[fifo_tail[7:0]] = e;
    fifo_tail = fifo_tail + 1;
  endtask

  task automatic wait_cycles_until_write(input int n, input int limit);
    int b = 0;
    while (got_wr.size() < n && b < limit) begin @(negedge clk); b++; end
    checkOutput("write_timeout", got_wr.size() >= n, 1);
  endtask

  // One whole copy command: reference walk first, then the DUT run, then compare.
  task automatic run_cmd(input cfg_t c, input logic [35:0] ents[$], input int rdd,
                         input int wrd, input int gap);
    wr_t exp_wr[$];
    int x, y, a, head0, budget;
    logic [1:0] m;
    logic [31:0] d, dm;
    logic [15:0] sm16;
    mvram = vram;
    x = int'(c.dx[9:1]);
    y = int'(c.dy);
    sm16 = c.sm ? 16'h8000 : 16'h0000;
    foreach (ents[i]) begin
      if (ents[i][33:32] != 2'b00) begin
        a = y * 512 + x;
        m = ents[i][33:32];
        if (c.cm) begin
          d = mvram.exists(a) ? mvram[a] : bg(a);
          if (d[15]) m[0] = 1'b0;
          if (d[31]) m[1] = 1'b0;
        end
        if (m != 2'b00) begin
          d = {ents[i][31:16] | sm16, ents[i][15:0] | sm16};
          exp_wr.push_back('{addr: 18'(a), data: d, mask: m, cyc: 0});
          dm = mvram.exists(a) ? mvram[a] : bg(a);
          if (m[0]) dm[15:0]  = d[15:0];
          if (m[1]) dm[31:16] = d[31:16];
          mvram[a] = dm;
        end
      end
      if (ents[i][34]) begin
        x = int'(c.dx[9:1]);
        y = (y + 1) % 512;
      end else x = (x + 1) % 512;
      if (ents[i][35]) break;
    end

    got_wr.delete();
    stable_log.delete();
    exit_count = 0;
    head0 = fifo_head;
    rd_delay = rdd;
    wr_delay = wrd;
    applyStimulus(c);
    if (gap == 0) foreach (ents[i]) push(ents[i]);
    @(negedge clk) active = 1'b1;
    if (gap > 0) begin
      foreach (ents[i]) begin
        push(ents[i]);
        budget = 0;
        while (fifo_head != fifo_tail && budget < 500) begin @(negedge clk); budget++; end
        repeat (gap) @(negedge clk);
      end
    end
    budget = 0;
    while (exit_count == 0 && budget < 3000) begin @(negedge clk); budget++; end
    repeat (2) @(negedge clk);
    active = 1'b0;
    @(negedge clk);
    checkOutput("exit_count", exit_count, 1);
    checkOutput("pops", fifo_head - head0, ents.size());
    checkOutput("wr_count", got_wr.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++) begin
      dm = {{16{exp_wr[i].mask[1]}}, {16{exp_wr[i].mask[0]}}};
      checkOutput("wr_addr", got_wr[i].addr, exp_wr[i].addr);
      checkOutput("wr_mask", got_wr[i].mask, exp_wr[i].mask);
      checkOutput("wr_data", got_wr[i].data & dm, exp_wr[i].data & dm);
      checkOutput("wr_stable", stable_log[i], 1);
    end
    fifo_tail = fifo_head;
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t tbl[8];
    logic [35:0] q[$];
    cfg_t c;
    int b, head0;

    // Single-entry directed rows: mask rules, set-mask, padding, far corner.
    tbl[0] = '{'{10'd4, 9'd10, 0, 0}, 16'h1234, 16'h5678, 2'b11, 32'h0, 1, {9'd10, 9'd2}, 32'h5678_1234, 2'b11};
    tbl[1] = '{'{10'd8, 9'd3, 1, 0}, 16'h1234, 16'h5678, 2'b11, 32'h8000_0000, 1, {9'd3, 9'd4}, 32'h0000_1234, 2'b01};
    tbl[2] = '{'{10'd8, 9'd4, 1, 0}, 16'h1234, 16'h5678, 2'b11, 32'h8000_8000, 0, 18'd0, 32'h0, 2'b00};
    tbl[3] = '{'{10'd0, 9'd0, 0, 1}, 16'h0001, 16'h7FFF, 2'b11, 32'h0, 1, {9'd0, 9'd0}, 32'hFFFF_8001, 2'b11};
    tbl[4] = '{'{10'd40, 9'd7, 1, 1}, 16'hAAAA, 16'h0055, 2'b11, 32'h0000_8000, 1, {9'd7, 9'd20}, 32'h8055_0000, 2'b10};
    tbl[5] = '{'{10'd100, 9'd9, 0, 0}, 16'h1111, 16'h2222, 2'b00, 32'h0, 0, 18'd0, 32'h0, 2'b00};
    tbl[6] = '{'{10'd2, 9'd1, 0, 0}, 16'h1111, 16'h5678, 2'b10, 32'h0, 1, {9'd1, 9'd1}, 32'h5678_0000, 2'b10};
    tbl[7] = '{'{10'd1023, 9'd511, 0, 0}, 16'h0BAD, 16'h0000, 2'b01, 32'h0, 1, {9'd511, 9'd511}, 32'h0000_0BAD, 2'b01};

    nRst = 1'b0; active = 1'b0; dstX = '0; dstY = '0; checkMask = 1'b0; setMask = 1'b0;
    rdAck = 1'b0; wrAck = 1'b0; rdData = '0;
    for (int i = 0; i < 256; i++) fifo_mem[i] = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_fifoPop", fifoPop, 0);
    checkOutput("rst_rdReq", rdReq, 0);
    checkOutput("rst_wrReq", wrReq, 0);
    checkOutput("rst_exitSig", exitSig, 0);
    checkOutput("rst_wrMask", wrMask, 0);
    checkOutput("rst_wrAddr", wrAddr, 0);
    checkOutput("rst_wrData", wrData, 0);
    nRst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      vram[int'({tbl[i].c.dy, tbl[i].c.dx[9:1]})] = tbl[i].dst;
      q = {mk(tbl[i].p0, tbl[i].p1, tbl[i].v, 1'b0, 1'b1)};
      run_cmd(tbl[i].c, q, 0, 0, 0);
      checkOutput($sformatf("tbl%0d_wr", i), got_wr.size(), tbl[i].exp_wr);
      if (tbl[i].exp_wr == 1 && got_wr.size() == 1) begin
        checkOutput($sformatf("tbl%0d_addr", i), got_wr[0].addr, tbl[i].exp_addr);
        checkOutput($sformatf("tbl%0d_mask", i), got_wr[0].mask, tbl[i].exp_mask);
        checkOutput($sformatf("tbl%0d_data", i),
                    got_wr[0].data & {{16{tbl[i].exp_mask[1]}}, {16{tbl[i].exp_mask[0]}}},
                    tbl[i].exp_data);
      end
    end

    // Two pairs, no stalls: three cycles per pair and exit one cycle after the last ack.
    q = {mk(16'hA1A1, 16'hB2B2, 2'b11, 0, 0), mk(16'hC3C3, 16'hD4D4, 2'b11, 0, 1)};
    run_cmd('{10'd4, 9'd10, 0, 0}, q, 0, 0, 0);
    if (got_wr.size() == 2) begin
      checkOutput("seq1_addr1", got_wr[1].addr, {9'd10, 9'd3});
      checkOutput("seq1_pair_gap", got_wr[1].cyc - got_wr[0].cyc, 3);
      checkOutput("seq1_exit_lat", exit_cyc - got_wr[1].cyc, 1);
    end

    // Check-mask adds exactly one cycle per pair when the read acks at once.
    vram[20 * 512 + 0] = 32'h0; vram[20 * 512 + 1] = 32'h0;
    q = {mk(16'h0001, 16'h0002, 2'b11, 0, 0), mk(16'h0003, 16'h0004, 2'b11, 0, 1)};
    run_cmd('{10'd0, 9'd20, 1, 0}, q, 0, 0, 0);
    if (got_wr.size() == 2) checkOutput("chk_pair_gap", got_wr[1].cyc - got_wr[0].cyc, 4);

    // X pair wrap at 511.
    q = {mk(16'h1, 16'h2, 2'b11, 0, 0), mk(16'h3, 16'h4, 2'b11, 0, 0), mk(16'h5, 16'h6, 2'b11, 0, 1)};
    run_cmd('{10'd1022, 9'd7, 0, 0}, q, 0, 0, 0);
    if (got_wr.size() == 3) begin
      checkOutput("wrap_addr0", got_wr[0].addr, {9'd7, 9'd511});
      checkOutput("wrap_addr1", got_wr[1].addr, {9'd7, 9'd0});
      checkOutput("wrap_addr2", got_wr[2].addr, {9'd7, 9'd1});
    end

    // Slow write acks and FIFO starved between entries.
    q = {mk(16'h10, 16'h20, 2'b11, 0, 0), mk(16'h30, 16'h40, 2'b11, 0, 0), mk(16'h50, 16'h60, 2'b11, 0, 1)};
    run_cmd('{10'd200, 9'd50, 0, 0}, q, 0, 5, 11);

    // Line break on the second entry with Y wrapping from 511 to 0.
    q = {mk(16'h7, 16'h8, 2'b11, 0, 0), mk(16'h9, 16'hA, 2'b11, 1, 0), mk(16'hB, 16'hC, 2'b11, 0, 1)};
    run_cmd('{10'd6, 9'd511, 0, 0}, q, 0, 0, 0);
    if (got_wr.size() == 3) begin
      checkOutput("crlf_addr1", got_wr[1].addr, {9'd511, 9'd4});
      checkOutput("crlf_addr2", got_wr[2].addr, {9'd0, 9'd3});
    end

    // Active drops while a write is held: request stays, no exit, no further pop.
    got_wr.delete(); exit_count = 0; head0 = fifo_head; wr_delay = 6;
    applyStimulus('{10'd0, 9'd30, 0, 0});
    push(mk(16'h1, 16'h2, 2'b11, 0, 0));
    push(mk(16'h3, 16'h4, 2'b11, 0, 1));
    @(negedge clk) active = 1'b1;
    b = 0;
    while (!wrReq && b < 50) begin @(negedge clk); b++; end
    active = 1'b0;
    @(negedge clk);
    checkOutput("drop_wr_held", wrReq, 1);
    wait_cycles_until_write(1, 50);
    repeat (8) @(negedge clk);
    checkOutput("drop_no_exit", exit_count, 0);
    checkOutput("drop_pops", fifo_head - head0, 1);
    checkOutput("drop_wr_idle", wrReq, 0);
    fifo_tail = fifo_head;

    // Reset during WRITE drops the request on the next cycle.
    wr_delay = 20;
    applyStimulus('{10'd20, 9'd5, 0, 0});
    push(mk(16'h1111, 16'h2222, 2'b11, 0, 1));
    @(negedge clk) active = 1'b1;
    b = 0;
    while (!wrReq && b < 50) begin @(negedge clk); b++; end
    checkOutput("rst_wr_seen", wrReq, 1);
    nRst = 1'b0;
    active = 1'b0;
    @(negedge clk);
    checkOutput("midrst_wrReq", wrReq, 0);
    checkOutput("midrst_rdReq", rdReq, 0);
    checkOutput("midrst_wrMask", wrMask, 0);
    checkOutput("midrst_wrAddr", wrAddr, 0);
    nRst = 1'b1;
    wr_delay = 0;
    fifo_tail = fifo_head;
    repeat (3) @(negedge clk);

    // Randomised commands against the reference walk.
    for (int n = 0; n < 30; n++) begin
      int len;
      q.delete();
      c.dx = 10'($urandom);
      c.dy = 9'($urandom);
      c.cm = 1'($urandom);
      c.sm = 1'($urandom);
      len = $urandom_range(1, 8);
      for (int k = 0; k < len; k++)
        q.push_back(mk(16'($urandom), 16'($urandom), 2'($urandom),
                       ($urandom_range(0, 3) == 0), (k == len - 1)));
      run_cmd(c, q, $urandom_range(0, 3), $urandom_range(0, 3),
              ($urandom_range(0, 4) == 0) ? 12 : 0);
    end

    checkOutput("never_both_req", both_req, 0);
    checkOutput("no_pop_when_empty", pop_while_empty, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
